// File: rtl/message_composer.sv
// message_composer: collects decoded keystrokes into a space-padded message
// buffer with backspace editing, commits it on Enter and holds it for the link
// transmitter until the send_done handshake completes, then clears for reuse.
module message_composer #(
    parameter int         MAX_CHARS  = 16,
    parameter logic [7:0] PAD_CHAR   = 8'h20,
    parameter logic [7:0] ENTER_CODE = 8'd13,
    parameter logic [7:0] BKSP_CODE  = 8'd8,
    localparam int        CNT_W      = $clog2(MAX_CHARS + 1),
    localparam int        MSG_W      = 8 * MAX_CHARS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             key_valid,
    input  logic [7:0]       key_ascii,
    input  logic             enable,
    input  logic             send_done,
    output logic [MSG_W-1:0] message_out,
    output logic [CNT_W-1:0] char_count,
    output logic             data_ready,
    output logic             echo_valid,
    output logic [7:0]       echo_char,
    output logic             reject
);

    typedef enum logic [1:0] {
        ST_EDIT = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [MSG_W-1:0] PAD_FILL = {MAX_CHARS{PAD_CHAR}};
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CHARS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Printable ASCII range accepted into the buffer.
    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

    state_t             state_q, state_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               echo_valid_q, echo_valid_d;
    logic [7:0]         echo_char_q, echo_char_d;
    logic               reject_q, reject_d;
    logic               kv_prev_q, kv_prev_d;
    logic               sd_s1_q, sd_s1_d;
    logic               sd_s2_q, sd_s2_d;

    logic               key_event;
    logic [CNT_W-1:0]   count_dec;
    logic [CNT_W+2:0]   slot_wr_off;
    logic [CNT_W+2:0]   slot_del_off;

    // Edge detector and send_done synchronizer inputs; the synchronizer keeps
    // the slow-domain level away from the FSM until it has settled two flops.
    always_comb begin
        kv_prev_d = key_valid;
        sd_s1_d   = send_done;
        sd_s2_d   = sd_s1_q;
    end

    // One event per key_valid assertion, and byte offsets of the write and
    // delete slots (next free slot, last used slot).
    always_comb begin
        key_event    = key_valid && !kv_prev_q;
        count_dec    = count_q - CNT_ONE;
        slot_wr_off  = {count_q, 3'b000};
        slot_del_off = {count_dec, 3'b000};
    end

    // FSM next state plus buffer editing; keys only act in EDIT with enable.
    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        count_d      = count_q;
        echo_valid_d = 1'b0;
        echo_char_d  = echo_char_q;
        reject_d     = 1'b0;

        unique case (state_q)
            ST_EDIT: begin
                if (key_event && enable) begin
                    if (is_printable(key_ascii)) begin
                        if (count_q < MAX_CNT) begin
                            msg_d[slot_wr_off +: 8] = key_ascii;
                            count_d                 = count_q + CNT_ONE;
                            echo_valid_d            = 1'b1;
                            echo_char_d             = key_ascii;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (key_ascii == BKSP_CODE) begin
                        if (count_q != '0) begin
                            msg_d[slot_del_off +: 8] = PAD_CHAR;
                            count_d                  = count_dec;
                            echo_valid_d             = 1'b1;
                            echo_char_d              = BKSP_CODE;
                        end
                    end else if (key_ascii == ENTER_CODE) begin
                        if (count_q != '0) begin
                            state_d = ST_SEND;
                        end
                    end
                end
            end
            ST_SEND: begin
                // A send_done already high here still counts as the acknowledge.
                if (sd_s2_q) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // Wait for send_done to drop so the next commit sees a fresh rise.
                if (!sd_s2_q) begin
                    state_d = ST_EDIT;
                    msg_d   = PAD_FILL;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_EDIT;
            end
        endcase
    end

    // All state registers; reset clears buffer, handshake and pulses together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_EDIT;
            msg_q        <= PAD_FILL;
            count_q      <= '0;
            echo_valid_q <= 1'b0;
            echo_char_q  <= 8'h00;
            reject_q     <= 1'b0;
            kv_prev_q    <= 1'b0;
            sd_s1_q      <= 1'b0;
            sd_s2_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            count_q      <= count_d;
            echo_valid_q <= echo_valid_d;
            echo_char_q  <= echo_char_d;
            reject_q     <= reject_d;
            kv_prev_q    <= kv_prev_d;
            sd_s1_q      <= sd_s1_d;
            sd_s2_q      <= sd_s2_d;
        end
    end

    // Output mapping; data_ready is a decode of the registered state.
    always_comb begin
        message_out = msg_q;
        char_count  = count_q;
        data_ready  = (state_q == ST_SEND);
        echo_valid  = echo_valid_q;
        echo_char   = echo_char_q;
        reject      = reject_q;
    end

endmodule

// File: tb/tb_message_composer.sv
// Bench for message_composer: directed test-plan sequences followed by random
// keystrokes and handshakes, all checked every cycle against a queue-based model.
module tb_message_composer;

    logic         clock;
    logic         reset;
    logic         key_valid;
    logic [7:0]   key_ascii;
    logic         enable;
    logic         send_done;
    logic [127:0] message_out;
    logic [4:0]   char_count;
    logic         data_ready;
    logic         echo_valid;
    logic [7:0]   echo_char;
    logic         reject;

    message_composer dut (
        .clock       (clock),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_ascii   (key_ascii),
        .enable      (enable),
        .send_done   (send_done),
        .message_out (message_out),
        .char_count  (char_count),
        .data_ready  (data_ready),
        .echo_valid  (echo_valid),
        .echo_char   (echo_char),
        .reject      (reject)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: the message is a queue of typed characters.
    logic [7:0] q[$];
    bit         committed;   // Enter accepted, message owned by the link
    bit         acked;       // link reported done, waiting for it to drop
    bit         prev_kv;
    bit         sd_hist[2];  // send_done as sampled one and two edges ago
    bit         m_echo;
    logic [7:0] m_echo_char;
    bit         m_rej;

    bit         auto_sd = 0;
    logic       sd_cmd  = 1'b0;
    int         echo_seen = 0;
    int         rej_seen  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_msg();
        logic [127:0] m;
        for (int i = 0; i < 16; i++)
            m[8*i +: 8] = (i < q.size()) ? q[i] : 8'h20;
        return m;
    endfunction

    task automatic model_edge(input logic r, input logic kv, input logic [7:0] code,
                              input logic en, input logic sd);
        bit ev, seen;
        m_echo = 0;
        m_rej  = 0;
        if (r) begin
            q.delete();
            committed = 0; acked = 0; prev_kv = 0;
            sd_hist[0] = 0; sd_hist[1] = 0;
            m_echo_char = 8'h00;
            return;
        end
        ev         = kv && !prev_kv;
        prev_kv    = kv;
        seen       = sd_hist[1];
        sd_hist[1] = sd_hist[0];
        sd_hist[0] = sd;
        if (!committed) begin
            if (ev && en) begin
                if (code >= 8'h20 && code <= 8'h7E) begin
                    if (q.size() < 16) begin
                        q.push_back(code);
                        m_echo = 1; m_echo_char = code;
                    end else begin
                        m_rej = 1;
                    end
                end else if (code == 8'd8) begin
                    if (q.size() > 0) begin
                        void'(q.pop_back());
                        m_echo = 1; m_echo_char = 8'd8;
                    end
                end else if (code == 8'd13) begin
                    if (q.size() > 0) committed = 1;
                end
            end
        end else if (!acked) begin
            if (seen) acked = 1;
        end else if (!seen) begin
            q.delete();
            committed = 0;
            acked     = 0;
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check just after.
    task automatic step(input logic r, input logic kv, input logic [7:0] code, input logic en);
        reset     = r;
        key_valid = kv;
        key_ascii = code;
        enable    = en;
        if (auto_sd) begin
            if (!send_done && committed && !acked && $urandom_range(0, 7) == 0)
                send_done = 1'b1;
            else if (!send_done && $urandom_range(0, 63) == 0)
                send_done = 1'b1;
            else if (send_done && $urandom_range(0, 2) == 0)
                send_done = 1'b0;
        end else begin
            send_done = sd_cmd;
        end
        @(posedge clock);
        model_edge(r, kv, code, en, send_done);
        #1;
        if (echo_valid) echo_seen++;
        if (reject) rej_seen++;
        chk("message_out", message_out, exp_msg());
        chk("char_count", 128'(char_count), 128'(q.size()));
        chk("data_ready", 128'(data_ready), 128'(committed && !acked));
        chk("echo_valid", 128'(echo_valid), 128'(m_echo));
        if (m_echo || r) chk("echo_char", 128'(echo_char), 128'(m_echo_char));
        chk("reject", 128'(reject), 128'(m_rej));
    endtask

    task automatic press(input logic [7:0] code, input int hold, input int gap, input logic en);
        for (int i = 0; i < hold; i++) step(1'b0, 1'b1, code, en);
        for (int i = 0; i < gap; i++)  step(1'b0, 1'b0, code, en);
    endtask

    initial begin
        int e0, r0;
        reset = 1'b1; key_valid = 1'b0; key_ascii = 8'h00; enable = 1'b0; send_done = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_msg", message_out, {16{8'h20}});
        chk("rst_cnt", 128'(char_count), 128'd0);

        // "Hi", each held 5 cycles
        e0 = echo_seen;
        press(8'h48, 5, 2, 1'b1);
        press(8'h69, 5, 2, 1'b1);
        chk("hi_low16", 128'(message_out[15:0]), 128'h6948);
        chk("hi_upper", 128'(message_out[127:16]), 128'({14{8'h20}}));
        chk("hi_cnt", 128'(char_count), 128'd2);
        chk("hi_echoes", 128'(echo_seen - e0), 128'd2);

        // 17 'a' then backspace
        step(1'b1, 1'b0, 8'h00, 1'b1);
        r0 = rej_seen;
        for (int i = 0; i < 17; i++) press(8'h61, 2, 1, 1'b1);
        chk("full_msg", message_out, {16{8'h61}});
        chk("full_cnt", 128'(char_count), 128'd16);
        chk("full_rej", 128'(rej_seen - r0), 128'd1);
        press(8'h08, 1, 0, 1'b1);
        chk("bksp_echo", 128'(echo_char), 128'h08);
        press(8'h00, 0, 1, 1'b1);
        chk("bksp_cnt", 128'(char_count), 128'd15);
        chk("bksp_b15", 128'(message_out[127:120]), 128'h20);

        // Empty buffer: backspace and Enter ignored
        step(1'b1, 1'b0, 8'h00, 1'b1);
        e0 = echo_seen;
        press(8'h08, 2, 2, 1'b1);
        press(8'h0D, 2, 2, 1'b1);
        chk("empty_echo", 128'(echo_seen - e0), 128'd0);
        chk("empty_rdy", 128'(data_ready), 128'd0);

        // "A" + Enter, keys while sending, full handshake
        press(8'h41, 2, 1, 1'b1);
        press(8'h0D, 2, 0, 1'b1);
        for (int i = 0; i < 10; i++) press(8'h7A, 1, 0, 1'b1);
        chk("send_hold", 128'(message_out[7:0]), 128'h41);
        chk("send_rdy", 128'(data_ready), 128'd1);
        sd_cmd = 1'b1;
        press(8'h00, 0, 4, 1'b1);
        sd_cmd = 1'b0;
        press(8'h00, 0, 5, 1'b1);
        chk("clr_msg", message_out, {16{8'h20}});

        // enable low: typed key discarded; enable raised under a held key
        press(8'h78, 2, 2, 1'b0);
        press(8'h79, 2, 0, 1'b0);
        press(8'h79, 3, 2, 1'b1);
        chk("en_cnt", 128'(char_count), 128'd0);

        // Reset during SEND, then a fresh key is accepted
        press(8'h51, 2, 1, 1'b1);
        press(8'h0D, 2, 1, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("srst_rdy", 128'(data_ready), 128'd0);
        press(8'h52, 2, 1, 1'b1);
        chk("srst_key", 128'(message_out[7:0]), 128'h52);

        // Random keystrokes, enables, handshakes and rare resets
        auto_sd = 1;
        for (int n = 0; n < 400; n++) begin
            int sel;
            logic [7:0] code;
            logic en;
            sel = $urandom_range(0, 99);
            if (sel < 70)      code = 8'($urandom_range(32, 126));
            else if (sel < 82) code = 8'h08;
            else if (sel < 88) code = 8'h0D;
            else               code = 8'($urandom_range(0, 31));
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) step(1'b1, 1'b0, 8'h00, en);
            press(code, $urandom_range(1, 4), $urandom_range(1, 3), en);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/message_composer.md
# message_composer

Keyboard-to-link message buffer sitting between the PS/2 `key2ascii` decode and the `gpio_protocol` transmitter. It accepts decoded ASCII keystrokes while the UI is in the sending state and assembles up to 16 characters into a 128-bit space-padded message, with backspace editing. On Enter it freezes the message and raises `data_ready` to the link. After the link's `done` handshake completes, it clears the buffer for the next message.

## Interface
Parameters:
- `MAX_CHARS`, 16: buffer capacity in characters; `message_out` width is `8*MAX_CHARS`.
- `PAD_CHAR`, 8'h20: fill byte for empty slots.
- `ENTER_CODE`, 8'd13: commit key.
- `BKSP_CODE`, 8'd8: delete-last key.

Ports:
- `clock`  in  1  system clock (CLOCK_50 domain); all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, one reset domain.
- `key_valid`  in  1  high while `key_ascii` is valid (scan_code_ready); may stay high for many cycles.
- `key_ascii`  in  8  decoded ASCII code.
- `enable`  in  1  composing allowed (UI in sending state).
- `send_done`  in  1  link completion level from `gpio_protocol` (asynchronous, slow domain).
- `message_out`  out  128  packed message; char i in bits [8i+7:8i], char 0 in [7:0].
- `char_count`  out  5  characters stored, 0..16.
- `data_ready`  out  1  message committed, awaiting link.
- `echo_valid`  out  1  one-cycle pulse per accepted edit (drives LCD write enable).
- `echo_char`  out  8  accepted character, or BKSP_CODE for a deletion.
- `reject`  out  1  one-cycle pulse: printable key refused because buffer full.

## Operation
- Reset values: `message_out` all PAD_CHAR, `char_count`=0, `data_ready`=0, `echo_valid`=0, `echo_char`=0, `reject`=0, FSM=EDIT, edge register=0, synchronizer=0.
- Key event: `key_valid` high while the registered previous `key_valid` is low. Exactly one event per assertion, however long it lasts.
- `send_done` passes a 2-flop synchronizer (`sd_s1`→`sd_s2`); the FSM uses `sd_s2` only.
- FSM states:
  - EDIT: events processed only when `enable`=1.
  - SEND: `data_ready`=1, `message_out` frozen. `sd_s2`=1 → ACK.
  - ACK: `data_ready`=0. `sd_s2`=0 → EDIT, with buffer cleared to PAD_CHAR and `char_count`=0.
- Event handling in EDIT with `enable`=1:
  - Printable (8'h20..8'h7E), `char_count`<MAX_CHARS: write slot `char_count`, increment, echo.
  - Printable, `char_count`=MAX_CHARS: no change, `reject` pulse.
  - BKSP_CODE, `char_count`>0: slot `char_count-1` ← PAD_CHAR, decrement, echo BKSP_CODE.
  - BKSP_CODE at `char_count`=0: ignored, no echo.
  - ENTER_CODE, `char_count`>0: → SEND, no echo. At `char_count`=0: ignored.
  - Any other code (including 8'h00): ignored.
- Events with `enable`=0, or in SEND/ACK: discarded, not queued. The edge register still tracks, so a key held across the return to EDIT produces no event.
- Buffer contents are retained while `enable`=0.
- `char_count` never exceeds MAX_CHARS and never wraps below 0.

## Timing
- Event sampled at edge n → `message_out`, `char_count`, `echo_valid`/`echo_char`, `reject` valid after edge n (registered, 1-cycle latency). Pulses last exactly one cycle.
- Enter sampled at edge n → `data_ready`=1 after edge n.
- `send_done` rises before edge k → `sd_s2`=1 after k+1 → FSM enters ACK and `data_ready`=0 after edge k+2.
- `send_done` falls before edge j → buffer cleared and FSM in EDIT after edge j+2. The first new event is accepted at edge j+3 or later.
- Reset asserted at any edge, in any state (including SEND mid-handshake), wins over all other inputs. All outputs return to reset values after that edge.
- Key event and `sd_s2` change in the same cycle: only the FSM transition applies; the key is discarded.
- `send_done` already high on entry to SEND: treated as an acknowledgement. ACK guarantees it was low before the previous clear.

## Test plan
- Reset, `enable`=1, type "Hi" (8'h48, 8'h69), each held 5 cycles → `char_count`=2; `message_out[15:0]`=16'h6948; upper 112 bits 8'h20; exactly two `echo_valid` pulses.
- Type 17 'a' (8'h61) → `char_count`=16, all bytes 8'h61, one `reject` pulse on the 17th; then BKSP → `char_count`=15, byte 15 = 8'h20, `echo_char`=8'h08.
- Empty buffer: BKSP then Enter → no echo, `char_count`=0, `data_ready` stays 0.
- "A" + Enter; 10 cycles later `send_done` high for 4 cycles then low:
  - `data_ready`=1 from the Enter cycle+1; keys typed meanwhile ignored; `message_out[7:0]`=8'h41 held.
  - `data_ready`=0 two cycles after `send_done` rises.
  - Buffer all 8'h20 and `char_count`=0 two cycles after `send_done` falls.
- `enable`=0: type 'x' → no change, no echo. Assert `enable` while still holding `key_valid` → no event.
- In SEND, assert `reset` for one cycle → `data_ready`=0, `message_out` all 8'h20, FSM accepts a new key on the following event.
